// File: rtl/fake_seq_pkg.sv
// Shared types and constants for the fake pulse sequencer: FSM states,
// descriptor field layout and fake ADC code limits.
package fake_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_DELAY,
      ST_PULSE,
      ST_NEXT,
      ST_FINISH
   } state_t;

   localparam int DELAY_LSB = 0;
   localparam int DELAY_W   = 32;
   localparam int WIDTH_LSB = 32;
   localparam int WIDTH_W   = 8;
   localparam int AMP_LSB   = 40;
   localparam int AMP_W     = 12;
   localparam int LAST_BIT  = 52;
   localparam int DESC_W    = 53;

   localparam int PEDESTAL    = 200;
   localparam int MAX_SIGNAL  = 2047;
   localparam int SIGNAL_BINS = MAX_SIGNAL - PEDESTAL;
   localparam int LG_SHIFT    = 5;

   typedef struct packed {
      logic               last;
      logic [AMP_W-1:0]   amp;
      logic [WIDTH_W-1:0] width;
      logic [DELAY_W-1:0] delay;
   } desc_t;

   function automatic desc_t unpack_desc(input logic [DESC_W-1:0] raw);
      desc_t d;
      d.delay = raw[DELAY_LSB +: DELAY_W];
      d.width = raw[WIDTH_LSB +: WIDTH_W];
      d.amp   = raw[AMP_LSB +: AMP_W];
      d.last  = raw[LAST_BIT];
      return d;
   endfunction

endpackage

// File: rtl/fake_pulse_sequencer_if.sv
// Configuration, control and status bundle of the fake pulse sequencer.
// Handshake: START is a one-cycle request taken only while BUSY is low and ABORT
// is low; BUSY rises the following cycle and falls in the cycle DONE pulses (or
// the cycle after ABORT). CFG_WE writes only while BUSY is low, else CFG_ERR pulses.
interface fake_pulse_sequencer_if #(
   parameter int ADDR_W = 3
);
   logic              CFG_WE;
   logic [ADDR_W-1:0] CFG_ADDR;
   logic [63:0]       CFG_DATA;
   logic              CFG_ERR;
   logic [15:0]       NUM_BURSTS;
   logic              START;
   logic              ABORT;
   logic              BUSY;
   logic              DONE;
   logic              ACTIVE;
   logic [ADDR_W-1:0] DESC_IDX;
   logic [15:0]       BURST_CNT;
   logic [23:0]       FAKE_SIGNAL;

   modport master (
      output CFG_WE, CFG_ADDR, CFG_DATA, NUM_BURSTS, START, ABORT,
      input  CFG_ERR, BUSY, DONE, ACTIVE, DESC_IDX, BURST_CNT, FAKE_SIGNAL
   );

   modport slave (
      input  CFG_WE, CFG_ADDR, CFG_DATA, NUM_BURSTS, START, ABORT,
      output CFG_ERR, BUSY, DONE, ACTIVE, DESC_IDX, BURST_CNT, FAKE_SIGNAL
   );
endinterface

// File: rtl/fake_seq_desc_ram.sv
// Descriptor table: single write port, synchronous read with one cycle latency.
// A write and a read of the same slot on one edge returns the new data.
module fake_seq_desc_ram #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 53
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);
   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
   end
endmodule

// File: rtl/fake_pulse_sequencer.sv
// Plays a software-loaded table of pulse descriptors as repeated bursts of fake
// HG/LG ADC words. Define FAKE_SEQ_LOOP_EN to make NUM_BURSTS==0 run until ABORT.
module fake_pulse_sequencer
   import fake_seq_pkg::*;
#(
   parameter int NUM_DESC = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   fake_pulse_sequencer_if.slave bus,
   output state_t                dbg_state
);
   localparam int          AW        = $clog2(NUM_DESC);
   localparam logic [11:0] PED_CODE  = 12'(PEDESTAL);
   localparam logic [11:0] BINS_CODE = 12'(SIGNAL_BINS);
`ifdef FAKE_SEQ_LOOP_EN
   localparam bit LOOP_EN = 1'b1;
`else
   localparam bit LOOP_EN = 1'b0;
`endif

   state_t          state, state_nxt;
   logic [AW-1:0]   idx, idx_nxt;
   logic [15:0]     num_q, num_nxt;
   logic [15:0]     bcnt, bcnt_nxt;
   logic [31:0]     dly_cnt, dly_nxt;
   logic [7:0]      pw_cnt, pw_nxt;
   logic [11:0]     amp_q, amp_nxt;
   logic            last_q, last_nxt;
   logic [23:0]     fake_q;
   logic            done_q, cfg_err_q;
   logic [DESC_W-1:0] rd_data;
   desc_t           rd_desc;
   logic            end_of_burst;
   logic            looping;
   logic [16:0]     bcnt_inc;
   logic            cfg_data_unused;

   assign cfg_data_unused = ^bus.CFG_DATA[63:DESC_W];

   // Read address follows the next index so the slot is ready during LOAD.
   fake_seq_desc_ram #(
      .DEPTH (NUM_DESC),
      .WIDTH (DESC_W)
   ) u_ram (
      .clk   (CLK),
      .we    (bus.CFG_WE && (state == ST_IDLE)),
      .waddr (bus.CFG_ADDR),
      .wdata (bus.CFG_DATA[DESC_W-1:0]),
      .raddr (idx_nxt),
      .rdata (rd_data)
   );

   assign rd_desc      = unpack_desc(rd_data);
   assign end_of_burst = last_q || (idx == AW'(NUM_DESC - 1));
   assign looping      = LOOP_EN && (num_q == 16'd0);
   assign bcnt_inc     = {1'b0, bcnt} + 17'd1;

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      num_nxt   = num_q;
      bcnt_nxt  = bcnt;
      dly_nxt   = dly_cnt;
      pw_nxt    = pw_cnt;
      amp_nxt   = amp_q;
      last_nxt  = last_q;
      if ((state != ST_IDLE) && bus.ABORT) begin
         state_nxt = ST_IDLE;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (bus.START && !bus.ABORT) begin
                  num_nxt   = bus.NUM_BURSTS;
                  idx_nxt   = '0;
                  bcnt_nxt  = '0;
                  state_nxt = ((bus.NUM_BURSTS == 16'd0) && !LOOP_EN) ? ST_FINISH : ST_LOAD;
               end
            end
            ST_LOAD: begin
               dly_nxt   = rd_desc.delay;
               pw_nxt    = (rd_desc.width == 8'd0) ? 8'd1 : rd_desc.width;
               amp_nxt   = (rd_desc.amp > BINS_CODE) ? BINS_CODE : rd_desc.amp;
               last_nxt  = rd_desc.last;
               state_nxt = (rd_desc.delay == 32'd0) ? ST_PULSE : ST_DELAY;
            end
            ST_DELAY: begin
               dly_nxt = dly_cnt - 32'd1;
               if (dly_cnt == 32'd1) state_nxt = ST_PULSE;
            end
            ST_PULSE: begin
               pw_nxt = pw_cnt - 8'd1;
               if (pw_cnt == 8'd1) state_nxt = ST_NEXT;
            end
            ST_NEXT: begin
               if (end_of_burst) begin
                  // Continuous runs wrap the burst count; bounded runs saturate.
                  if (looping) bcnt_nxt = bcnt + 16'd1;
                  else         bcnt_nxt = (&bcnt) ? bcnt : bcnt + 16'd1;
                  if (looping || (bcnt_inc < {1'b0, num_q})) begin
                     idx_nxt   = '0;
                     state_nxt = ST_LOAD;
                  end else begin
                     state_nxt = ST_FINISH;
                  end
               end else begin
                  idx_nxt   = idx + AW'(1);
                  state_nxt = ST_LOAD;
               end
            end
            ST_FINISH: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= ST_IDLE;
         idx       <= '0;
         num_q     <= '0;
         bcnt      <= '0;
         dly_cnt   <= '0;
         pw_cnt    <= '0;
         amp_q     <= '0;
         last_q    <= 1'b0;
         fake_q    <= {PED_CODE, PED_CODE};
         done_q    <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         idx       <= idx_nxt;
         num_q     <= num_nxt;
         bcnt      <= bcnt_nxt;
         dly_cnt   <= dly_nxt;
         pw_cnt    <= pw_nxt;
         amp_q     <= amp_nxt;
         last_q    <= last_nxt;
         done_q    <= (state == ST_FINISH) && !bus.ABORT;
         cfg_err_q <= bus.CFG_WE && (state != ST_IDLE);
         if (state == ST_PULSE)
            fake_q <= {amp_q + PED_CODE, (amp_q >> LG_SHIFT) + PED_CODE};
         else
            fake_q <= {PED_CODE, PED_CODE};
      end
   end

   assign bus.BUSY        = (state != ST_IDLE);
   assign bus.ACTIVE      = (state == ST_PULSE);
   assign bus.DONE        = done_q;
   assign bus.CFG_ERR     = cfg_err_q;
   assign bus.DESC_IDX    = idx;
   assign bus.BURST_CNT   = bcnt;
   assign bus.FAKE_SIGNAL = fake_q;
   assign dbg_state       = state;
endmodule

// File: tb/tb_fake_pulse_sequencer.sv
// Bench for fake_pulse_sequencer: directed and random descriptor tables checked
// cycle by cycle against a schedule computed from the sequencing rules.
module tb_fake_pulse_sequencer;
   import fake_seq_pkg::*;

   localparam int NUM_DESC = 8;
   localparam int PED      = 200;
   localparam int BINS     = 1847;
   localparam int NEVER    = 1 << 30;
   localparam logic [23:0] PED_WORD = 24'h0C80C8;

   logic   clk = 1'b0;
   logic   rst;
   state_t dbg_state;

   always #4 clk = ~clk;

   fake_pulse_sequencer_if bus ();

   fake_pulse_sequencer #(.NUM_DESC(NUM_DESC)) dut (
      .CLK       (clk),
      .RST       (rst),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   int tests_run    = 0;
   int tests_failed = 0;

   // Software's view of the descriptor table.
   int t_delay [NUM_DESC];
   int t_width [NUM_DESC];
   int t_amp   [NUM_DESC];
   bit t_last  [NUM_DESC];

   // act_q[k]: amplitude played at cycle k after START (-1 = no pulse).
   int act_q [$];
   // eob_q: cycles at which a burst completes.
   int eob_q [$];

   function automatic logic [23:0] exp_word(input int amp);
      int c;
      c = (amp > BINS) ? BINS : amp;
      return {12'(c + PED), 12'((c >> 5) + PED)};
   endfunction

   task automatic build_model(input int nb, input bit looping);
      act_q.delete();
      eob_q.delete();
      act_q.push_back(-1);
      for (int b = 0; b < nb; b++) begin
         int i;
         bit eob;
         i = 0;
         do begin
            act_q.push_back(-1);
            for (int c = 0; c < t_delay[i]; c++) act_q.push_back(-1);
            for (int c = 0; c < ((t_width[i] == 0) ? 1 : t_width[i]); c++) act_q.push_back(t_amp[i]);
            act_q.push_back(-1);
            eob = t_last[i] || (i == NUM_DESC - 1);
            if (eob) eob_q.push_back(act_q.size() - 1);
            i++;
         end while (!eob);
      end
      if (!looping) act_q.push_back(-1);
   endtask

   task automatic write_desc(input int i, input int d, input int w, input int a, input bit l);
      @(posedge clk); #1;
      bus.CFG_WE   = 1'b1;
      bus.CFG_ADDR = 3'(i);
      bus.CFG_DATA = {11'($urandom_range(0, 2047)), l, 12'(a), 8'(w), 32'(d)};
      t_delay[i] = d;
      t_width[i] = w;
      t_amp[i]   = a;
      t_last[i]  = l;
      @(posedge clk); #1;
      bus.CFG_WE = 1'b0;
   endtask

   task automatic run_seq(input string name, input int nb, input bit looping,
                          input int inj_off, input int abort_in);
      int          done_off, abort_off, last_off, exp_bc, j;
      logic [23:0] ef;
      logic        eb, ed, ea, ee;
      build_model(nb, looping);
      abort_off = looping ? act_q.size() : abort_in;
      done_off  = (abort_off >= 0) ? NEVER : act_q.size();
      last_off  = (abort_off >= 0) ? abort_off + 3 : done_off + 1;
      exp_bc = 0;
      foreach (eob_q[n]) if (abort_off < 0 || eob_q[n] < abort_off) exp_bc++;

      @(posedge clk); #1;
      bus.NUM_BURSTS = 16'(nb);
      bus.START      = 1'b1;
      for (int k = 1; k <= last_off; k++) begin
         @(posedge clk); #1;
         bus.START  = 1'b0;
         bus.ABORT  = 1'b0;
         bus.CFG_WE = 1'b0;
         if (k == inj_off) begin
            bus.CFG_WE   = 1'b1;
            bus.CFG_ADDR = 3'd0;
            bus.CFG_DATA = {$urandom, $urandom};
            bus.START    = 1'b1;
         end
         if (k == abort_off) bus.ABORT = 1'b1;
         @(negedge clk);
         j  = k - 1;
         ef = (j < act_q.size() && act_q[j] >= 0 && (abort_off < 0 || j <= abort_off))
              ? exp_word(act_q[j]) : PED_WORD;
         ea = (k < act_q.size() && act_q[k] >= 0 && (abort_off < 0 || k <= abort_off));
         eb = (abort_off >= 0) ? (k <= abort_off) : (k < done_off);
         ed = (k == done_off);
         ee = (k == inj_off + 1) && (inj_off >= 0);
         tests_run += 5;
         if (bus.FAKE_SIGNAL !== ef) begin
            tests_failed++;
            $display("FAIL %s fake_signal cycle %0d: got %h expected %h", name, k, bus.FAKE_SIGNAL, ef);
         end
         if (bus.ACTIVE !== ea) begin
            tests_failed++;
            $display("FAIL %s active cycle %0d: got %b expected %b", name, k, bus.ACTIVE, ea);
         end
         if (bus.BUSY !== eb) begin
            tests_failed++;
            $display("FAIL %s busy cycle %0d: got %b expected %b", name, k, bus.BUSY, eb);
         end
         if (bus.DONE !== ed) begin
            tests_failed++;
            $display("FAIL %s done cycle %0d: got %b expected %b", name, k, bus.DONE, ed);
         end
         if (bus.CFG_ERR !== ee) begin
            tests_failed++;
            $display("FAIL %s cfg_err cycle %0d: got %b expected %b", name, k, bus.CFG_ERR, ee);
         end
      end
      tests_run++;
      if (bus.BURST_CNT !== 16'(exp_bc)) begin
         tests_failed++;
         $display("FAIL %s burst_cnt: got %0d expected %0d", name, bus.BURST_CNT, exp_bc);
      end
   endtask

   task automatic test_reset();
      rst            = 1'b1;
      bus.CFG_WE     = 1'b0;
      bus.CFG_ADDR   = '0;
      bus.CFG_DATA   = '0;
      bus.NUM_BURSTS = '0;
      bus.START      = 1'b0;
      bus.ABORT      = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      tests_run += 7;
      if (bus.FAKE_SIGNAL !== PED_WORD) begin
         tests_failed++;
         $display("FAIL reset fake_signal: got %h expected %h", bus.FAKE_SIGNAL, PED_WORD);
      end
      if (bus.BUSY !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset busy: got %b expected 0", bus.BUSY);
      end
      if (bus.DONE !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset done: got %b expected 0", bus.DONE);
      end
      if (bus.ACTIVE !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset active: got %b expected 0", bus.ACTIVE);
      end
      if (bus.CFG_ERR !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset cfg_err: got %b expected 0", bus.CFG_ERR);
      end
      if (bus.DESC_IDX !== 3'd0) begin
         tests_failed++;
         $display("FAIL reset desc_idx: got %0d expected 0", bus.DESC_IDX);
      end
      if (bus.BURST_CNT !== 16'd0) begin
         tests_failed++;
         $display("FAIL reset burst_cnt: got %0d expected 0", bus.BURST_CNT);
      end
   endtask

   task automatic test_single_pulse();
      write_desc(0, 10, 4, 1000, 1'b1);
      run_seq("single_pulse", 1, 1'b0, -1, -1);
   endtask

   task automatic test_multi_burst();
      write_desc(0, 0, 1, 100, 1'b0);
      write_desc(1, 5, 2, 3000, 1'b1);
      run_seq("multi_burst", 3, 1'b0, -1, -1);
   endtask

   task automatic test_abort();
      write_desc(0, 0, 1, 100, 1'b0);
      write_desc(1, 5, 2, 3000, 1'b1);
      // Cycle 19 falls in the DELAY of slot 1 during the second burst.
      run_seq("abort_delay", 3, 1'b0, -1, 19);
      run_seq("abort_pulse", 3, 1'b0, -1, 14);
      @(posedge clk); #1;
      bus.NUM_BURSTS = 16'd2;
      bus.START      = 1'b1;
      bus.ABORT      = 1'b1;
      @(posedge clk); #1;
      bus.START = 1'b0;
      bus.ABORT = 1'b0;
      @(negedge clk);
      tests_run++;
      if (bus.BUSY !== 1'b0) begin
         tests_failed++;
         $display("FAIL abort_over_start busy: got %b expected 0", bus.BUSY);
      end
   endtask

   task automatic test_cfg_while_busy();
      write_desc(0, 30, 3, 500, 1'b1);
      run_seq("cfg_busy", 1, 1'b0, 10, -1);
      run_seq("cfg_readback", 1, 1'b0, -1, -1);
   endtask

   task automatic test_zero_bursts();
      write_desc(0, 0, 1, 700, 1'b1);
`ifdef FAKE_SEQ_LOOP_EN
      run_seq("loop_100", 100, 1'b1, -1, -1);
`else
      run_seq("zero_bursts", 0, 1'b0, -1, -1);
`endif
   endtask

   task automatic test_random();
      for (int it = 0; it < 5; it++) begin
         for (int s = 0; s < NUM_DESC; s++)
            write_desc(s, $urandom_range(0, 12), $urandom_range(0, 4), $urandom_range(0, 4095),
                       ($urandom_range(0, 3) == 0));
         run_seq("random", $urandom_range(1, 3), 1'b0, $urandom_range(1, 3), -1);
      end
   endtask

   initial begin
      test_reset();
      test_single_pulse();
      test_multi_burst();
      test_abort();
      test_cfg_while_busy();
      test_zero_bursts();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
